decode_block: RTL and testbench
===============================

Name: decode_block

Overview:
- Issue/decode stage that feeds the execution block and retires its results.
- Accepts 16-bit instruction words via a valid/ready handshake and decodes the 6-bit opcode.
- Reads a 32x16 register file and drives registered op_dec/A/B into the execution block.
- Writes ans_ex back into the register file one cycle after issue and latches flag_ex.

Parameters:
DW, 16, data width of the register file and of A/B/ans_ex
AW, 5, register address width
NREG, 32, number of registers (2**AW)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
ins  in  16  instruction word: [15:10] opcode, [9:5] rd, [4:0] rs/imm5
ins_valid  in  1  ins holds a valid instruction
ins_ready  out  1  block accepts ins this cycle
ans_ex  in  16  execution result for the instruction currently on op_dec/A/B
flag_ex  in  2  execution flags for that same instruction
op_dec  out  6  registered opcode to the execution block
A  out  16  registered operand A = R[rd]
B  out  16  registered operand B = R[rs] or sign-extended imm5
dec_valid  out  1  op_dec/A/B hold a real instruction; 0 means bubble
flags  out  2  flag_ex latched at the last retire

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: op_dec=0, A=0, B=0, dec_valid=0, flags=0, ins_ready=0 during reset, all registers R0..R31=0, rd_q=0.
- Accept: the instruction is taken on an edge where ins_valid && ins_ready.
  - At that edge: op_dec<=ins[15:10], A<=R[rd], B<=operand, rd_q<=rd, dec_valid<=1.
  - Latency is 1 cycle.
- No accept: the edge loads dec_valid<=0 (bubble). op_dec/A/B hold their previous values.
- Opcode classes:
  - IMM = op[5:3]==3'b010 (010000..010111). B = {{11{imm5[4]}}, imm5}.
  - STORE = op[5:2]==4'b0111 (011100..011111). B = R[rs]. No register write.
  - All other opcodes: B = R[rs]; result is written back.
- Retire: on every edge where dec_valid=1, flags<=flag_ex.
  - If the class is not STORE and rd_q!=0, also R[rd_q]<=ans_ex.
- R0 always reads 0. Writes to R0 are discarded.
- Hazard: the incoming instruction reads rd_q while the previous instruction retires this cycle (dec_valid=1, writes, rd_q!=0).
  - Match condition: rd==rd_q, or rs==rd_q and the class is not IMM.
  - Hazard handling is set by the optional feature below.
- Simultaneous retire and accept are always allowed when there is no hazard.
- Reset mid-operation: any accepted or in-flight instruction is dropped and nothing is written. dec_valid=0 on the cycle after reset.

Optional Feature:
- Macro: DECODE_FWD_EN.
- Defined: hazard operands are bypassed from ans_ex (write-through). ins_ready=1 whenever not in reset, so there are no stalls.
- Undefined: on a hazard, ins_ready=0 for one cycle and a bubble is issued.
  - The retire write completes at that edge.
  - The next cycle reads the updated register file.
- Register contents and the final results are identical with or without the macro; only timing differs.

Decomposition:
- Shared package decode_pkg:
  - field position constants OP_HI/OP_LO, RD_HI/RD_LO, RS_HI/RS_LO
  - opcode class constants CLS_IMM=3'b010, CLS_STORE=4'b0111
  - function is_imm(op) and function is_store(op)
  - DW/AW defaults
- Sub-module reg_file:
  - NREG x DW storage, one synchronous write port with R0 write-ignore
  - two combinational read ports, synchronous clear on reset
- Hazard/bypass logic stays in decode_block.

Test Plan:
1. Hold reset 2 cycles, then release.
   - During reset: ins_ready=0.
   - After release: op_dec=0, A=0, B=0, dec_valid=0, flags=0.
   - ins_ready=1 the cycle after release.
2. Issue ins={010000,rd=1,imm=5'b00101}.
   - Next cycle: op_dec=6'b010000, A=0, B=16'h0005, dec_valid=1.
   - Drive ans_ex=16'h0005, flag_ex=2'b01; then R1=5 and flags=2'b01.
3. Issue ins={010001,rd=2,imm=5'b10000}.
   - B=16'hFFF0.
   - After retiring ans_ex=16'hC000: R2=16'hC000.
4. Back-to-back issue: {010000,rd=1,imm=7}, then {000000,rd=3,rs=1} with ans_ex=16'h0007.
   - With DECODE_FWD_EN: no stall, B=16'h0007.
   - Without: ins_ready=0 for one cycle, one bubble (dec_valid=0), then B=16'h0007.
5. Issue STORE {011100,rd=3,rs=1} with ans_ex=16'h1234.
   - R3 is unchanged.
   - Issue {010000,rd=0,imm=9}; a later read of R0 gives A=0.
6. Accept an instruction, then assert reset on the next edge.
   - dec_valid=0 and no register write occurs.
   - All registers read 0 after release.

Source files
------------

// File: rtl/decode_block_pkg.sv
// Shared decode definitions: instruction field positions, opcode classes and
// width defaults for the issue/decode stage.
package decode_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_AW   = 5;
  localparam int DEF_NREG = 32;

  localparam int OP_HI = 15;
  localparam int OP_LO = 10;
  localparam int RD_HI = 9;
  localparam int RD_LO = 5;
  localparam int RS_HI = 4;
  localparam int RS_LO = 0;

  localparam logic [2:0] CLS_IMM   = 3'b010;
  localparam logic [3:0] CLS_STORE = 4'b0111;

  typedef struct packed {
    logic [OP_HI-OP_LO:0] op;
    logic [RD_HI-RD_LO:0] rd;
    logic [RS_HI-RS_LO:0] rs;
  } ins_t;

  function automatic logic is_imm(input logic [5:0] op);
    return op[5:3] == CLS_IMM;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op[5:2] == CLS_STORE;
  endfunction

endpackage

// File: rtl/decode_block_reg_file.sv
// NREG x DW register file: one synchronous write port, two combinational read
// ports, R0 hard-wired to zero, synchronous clear on reset.
module reg_file
  import decode_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREG = DEF_NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/decode_block.sv
// Issue/decode stage: decodes ins, reads operands, retires ans_ex one cycle
// after issue. Define DECODE_FWD_EN to bypass hazards instead of stalling.
//
// Handshake: ins is taken on a rising edge where ins_valid && ins_ready;
// ins_ready may depend combinationally on ins (hazard check) and on reset.
module decode_block
  import decode_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREG = DEF_NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   ins,
  input  logic          ins_valid,
  output logic          ins_ready,
  input  logic [DW-1:0] ans_ex,
  input  logic [1:0]    flag_ex,
  output logic [5:0]    op_dec,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          dec_valid,
  output logic [1:0]    flags
);

  ins_t          w_ins;
  logic [DW-1:0] w_ra;
  logic [DW-1:0] w_rb;
  logic [DW-1:0] w_imm_b;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic          w_we;
  logic          w_hit_a;
  logic          w_hit_b;
  logic          w_hazard;
  logic          w_accept;

  logic [5:0]    r_op_dec;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_dec_valid;
  logic [1:0]    r_flags;
  logic [AW-1:0] r_rd_q;

  assign w_ins   = ins;
  assign w_imm_b = {{(DW-5){w_ins.rs[4]}}, w_ins.rs};

  // The in-flight instruction retires on this edge; op_dec still holds its opcode.
  assign w_we     = r_dec_valid && !is_store(r_op_dec) && (r_rd_q != '0);
  assign w_hit_a  = w_we && (w_ins.rd == r_rd_q);
  assign w_hit_b  = w_we && !is_imm(w_ins.op) && (w_ins.rs == r_rd_q);
  assign w_hazard = w_hit_a || w_hit_b;

`ifdef DECODE_FWD_EN
  assign w_a       = w_hit_a ? ans_ex : w_ra;
  assign w_b       = is_imm(w_ins.op) ? w_imm_b : (w_hit_b ? ans_ex : w_rb);
  assign ins_ready = !reset;
`else
  assign w_a       = w_ra;
  assign w_b       = is_imm(w_ins.op) ? w_imm_b : w_rb;
  assign ins_ready = !reset && !w_hazard;
`endif

  assign w_accept = ins_valid && ins_ready;

  reg_file #(
    .DW   (DW),
    .AW   (AW),
    .NREG (NREG)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (r_rd_q),
    .i_wdata   (ans_ex),
    .i_raddr_a (w_ins.rd),
    .o_rdata_a (w_ra),
    .i_raddr_b (w_ins.rs),
    .o_rdata_b (w_rb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_dec    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_dec_valid <= 1'b0;
      r_flags     <= '0;
      r_rd_q      <= '0;
    end else begin
      r_dec_valid <= w_accept;
      if (w_accept) begin
        r_op_dec <= w_ins.op;
        r_a      <= w_a;
        r_b      <= w_b;
        r_rd_q   <= w_ins.rd;
      end
      if (r_dec_valid) r_flags <= flag_ex;
    end
  end

  assign op_dec    = r_op_dec;
  assign A         = r_a;
  assign B         = r_b;
  assign dec_valid = r_dec_valid;
  assign flags     = r_flags;

endmodule

// File: tb/tb_decode_block.sv
// Scoreboard bench for decode_block: a program-order register model predicts
// op_dec/A/B per accepted instruction; a negedge monitor checks and retires.
module tb_decode_block;

  localparam int W = 56;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [15:0] ans_ex = '0;
  logic [1:0]  flag_ex = '0;
  logic [5:0]  op_dec;
  logic [15:0] A;
  logic [15:0] B;
  logic        dec_valid;
  logic [1:0]  flags;

  logic [W-1:0] exp_q[$];
  logic [15:0]  m_reg [32];
  int           checks = 0;
  int           failures = 0;
  logic         rst_d = 1'b0;
  logic         pend = 1'b0;
  logic [1:0]   pend_flag = '0;
  logic [1:0]   exp_flags = '0;

  decode_block dut (
    .clk       (clk),
    .reset     (reset),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ans_ex    (ans_ex),
    .flag_ex   (flag_ex),
    .op_dec    (op_dec),
    .A         (A),
    .B         (B),
    .dec_valid (dec_valid),
    .flags     (flags)
  );

  // clock / reset sampling
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    rst_d = reset;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one instruction, wait for acceptance, record expectation
  task automatic issue(input logic [15:0] w, input logic [15:0] ans, input logic [1:0] fl,
                       output int waits);
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [15:0] ea;
    logic [15:0] eb;
    bit          ok;
    op = w[15:10];
    rd = w[9:5];
    rs = w[4:0];
    ins = w;
    ins_valid = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      #2;
      if (ins_ready === 1'b1) ok = 1'b1;
      else begin
        waits++;
        if (waits > 20) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout: ins %0h never accepted", w);
          ok = 1'b1;
        end
      end
    end
    if (waits <= 20) begin
      ea = m_reg[rd];
      eb = (op[5:3] == 3'b010) ? {{11{rs[4]}}, rs} : m_reg[rs];
      exp_q.push_back({op, ea, eb, ans, fl});
      if (!(op[5:2] == 4'b0111) && rd != 5'd0) m_reg[rd] = ans;
    end
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    ins = 16'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial forever begin
    logic [W-1:0] e;
    @(negedge clk);
    if (rst_d) begin
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_op_dec", op_dec, 0);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_flags", flags, 0);
      exp_q.delete();
      pend = 1'b0;
      exp_flags = '0;
    end else begin
      if (pend) exp_flags = pend_flag;
      pend = 1'b0;
      chk("flags", flags, exp_flags);
      if (dec_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: op_dec=%0h A=%0h B=%0h with empty queue", op_dec, A, B);
        end else begin
          e = exp_q.pop_front();
          chk("op_dec", op_dec, e[55:50]);
          chk("A", A, e[49:34]);
          chk("B", B, e[33:18]);
          ans_ex = e[17:2];
          flag_ex = e[1:0];
          pend = 1'b1;
          pend_flag = e[1:0];
        end
      end else begin
        ans_ex = 16'($urandom);
        flag_ex = 2'($urandom);
      end
    end
    if (reset) chk("ready_in_reset", ins_ready, 0);
  end

  // stimulus
  initial begin
    int waits;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    do_reset();
    @(negedge clk);
    #2;
    chk("ready_after_reset", ins_ready, 1);
    @(posedge clk);
    #1;

    issue({6'b010000, 5'd1, 5'b00101}, 16'h0005, 2'b01, waits);
    idle(2);
    issue({6'b010001, 5'd2, 5'b10000}, 16'hC000, 2'b10, waits);
    idle(2);
    issue({6'b010000, 5'd1, 5'd7}, 16'h0007, 2'b11, waits);
    issue({6'b000000, 5'd3, 5'd1}, 16'h00AA, 2'b00, waits);
`ifdef DECODE_FWD_EN
    chk("hazard_stall_cycles", waits, 0);
`else
    chk("hazard_stall_cycles", waits, 1);
`endif
    idle(2);
    issue({6'b011100, 5'd3, 5'd1}, 16'h1234, 2'b01, waits);
    issue({6'b010000, 5'd0, 5'd9}, 16'h5555, 2'b10, waits);
    issue({6'b011100, 5'd0, 5'd2}, 16'h0000, 2'b00, waits);
    issue({6'b011101, 5'd3, 5'd2}, 16'h0000, 2'b00, waits);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        w[9:5] = 5'($urandom_range(0, 3));
        w[4:0] = 5'($urandom_range(0, 3));
      end
      issue(w, 16'($urandom), 2'($urandom), waits);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    issue({6'b000000, 5'd1, 5'd2}, 16'hBEEF, 2'b11, waits);
    do_reset();
    idle(1);
    for (int k = 0; k < 32; k++) begin
      issue({6'b011100, 5'(k), 5'(31 - k)}, 16'($urandom), 2'($urandom), waits);
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
